// File: rtl/image_transfer_scheduler_pkg.sv
// Shared state encoding and default sizing for the image transfer scheduler.
package image_transfer_scheduler_pkg;

  localparam int ADDR_W        = 16;
  localparam int DATA_W        = 8;
  localparam int CNT_W         = 17;     // one bit beyond ADDR_W so a full 64 KiB load ends cleanly
  localparam int DEF_IMG_BYTES = 65536;
  localparam int DEF_OUT_BYTES = 16384;

  // Encoding doubles as the state_led value.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PROC = 3'd2,
    ST_RD   = 3'd3,
    ST_SEND = 3'd4,
    ST_HOLD = 3'd5,
    ST_WAIT = 3'd6,
    ST_DONE = 3'd7
  } state_t;

endpackage

// File: rtl/image_transfer_scheduler_tx_byte_sequencer.sv
// Dump path: reads OUT_BYTES bytes from OUT_BASE and hands each to the UART.
//
// Handshake with the UART transmitter: tx_start is a single-cycle request
// that is only raised after tx_busy was seen low; tx_data is registered on
// the same edge as tx_start and held until the next request. The UART is
// expected to raise tx_busy by the cycle after tx_start (HOLD covers this),
// and the next byte is not offered until tx_busy drops again.
module tx_byte_sequencer
  import image_transfer_scheduler_pkg::*;
#(
  parameter int OUT_BYTES = DEF_OUT_BYTES,
  parameter int OUT_BASE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output state_t            seq_state
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(OUT_BYTES - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(OUT_BASE);

  state_t            state;
  logic [ADDR_W-1:0] count;
  logic              tx_start_q;
  logic [DATA_W-1:0] tx_data_q;

  // Byte loop: RD presents the address, SEND captures the read data once the UART is free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            count <= '0;
            state <= ST_RD;
          end
        end
        ST_RD:   state <= ST_SEND;
        ST_SEND: begin
          if (!tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= rd_data;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: state <= ST_WAIT;
        ST_WAIT: begin
          if (!tx_busy) begin
            if (count == LAST) begin
              state <= ST_DONE;
            end else begin
              count <= count + ADDR_W'(1);
              state <= ST_RD;
            end
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Address wraps modulo 2^16 by construction of the 16-bit add.
  assign rd_addr   = BASE + count;
  assign tx_start  = tx_start_q & ~rst;
  assign tx_data   = tx_data_q;
  assign done      = (state == ST_DONE);
  assign seq_state = state;

endmodule

// File: rtl/image_transfer_scheduler.sv
// Top: UART image load into data memory, processor kick-off, then result dump.
module image_transfer_scheduler
  import image_transfer_scheduler_pkg::*;
#(
  parameter int IMG_BYTES = DEF_IMG_BYTES,
  parameter int OUT_BYTES = DEF_OUT_BYTES,
  parameter int OUT_BASE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              proc_start,
  input  logic              proc_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        state_led,
  output logic              xfer_done,
  output logic [ADDR_W-1:0] dbg_addr
);

  localparam logic [CNT_W-1:0] IMG_LAST = CNT_W'(IMG_BYTES - 1);

  // Top-level phase; ST_RD here means "dump owned by the sequencer".
  state_t            state;
  logic [CNT_W-1:0]  count;
  logic              proc_first;   // high only in the PROC entry cycle
  logic              load_wr;
  logic              seq_start;
  logic              seq_done;
  logic [ADDR_W-1:0] rd_addr;
  state_t            seq_state;
  state_t            led_state;

  assign load_wr   = (state == ST_LOAD) && rx_valid && !rst;
  // A proc_done level left over from a previous run is ignored in the entry cycle.
  assign seq_start = (state == ST_PROC) && !proc_first && proc_done;

  // Load/process sequencing; the dump itself runs inside the sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      count      <= '0;
      proc_first <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          count <= '0;
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (rx_valid) begin
            count <= count + CNT_W'(1);
            if (count == IMG_LAST) begin
              state      <= ST_PROC;
              proc_first <= 1'b1;
            end
          end
        end
        ST_PROC: begin
          proc_first <= 1'b0;
          if (seq_start) begin
            count <= '0;
            state <= ST_RD;
          end
        end
        ST_RD: begin
          if (seq_done) state <= ST_DONE;
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  tx_byte_sequencer #(
    .OUT_BYTES (OUT_BYTES),
    .OUT_BASE  (OUT_BASE)
  ) u_tx_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (seq_start),
    .done      (seq_done),
    .rd_addr   (rd_addr),
    .rd_data   (mem_rdata),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .seq_state (seq_state)
  );

  assign led_state  = (state == ST_RD) ? seq_state : state;
  assign state_led  = led_state;
  assign xfer_done  = (led_state == ST_DONE);
  assign mem_addr   = (state == ST_RD) ? rd_addr : count[ADDR_W-1:0];
  assign mem_we     = load_wr;
  assign mem_wdata  = load_wr ? rx_data : '0;
  assign proc_start = proc_first & ~rst;
  assign dbg_addr   = mem_addr;

endmodule

// File: tb/tb_image_transfer_scheduler.sv
// Bench for image_transfer_scheduler: small config (4 in, 2 out at 0x10) plus a full-size load.
module tb_image_transfer_scheduler;
  import image_transfer_scheduler_pkg::*;

  localparam int IMG  = 4;
  localparam int OUTN = 2;
  localparam int BASE = 16'h10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rx_valid, tx_busy, proc_done;
  logic        tx_start, proc_start, mem_we, xfer_done;
  logic [7:0]  rx_data, tx_data, mem_wdata, mem_rdata;
  logic [15:0] mem_addr, dbg_addr;
  logic [2:0]  state_led;

  image_transfer_scheduler #(.IMG_BYTES(IMG), .OUT_BYTES(OUTN), .OUT_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .proc_start(proc_start), .proc_done(proc_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .state_led(state_led), .xfer_done(xfer_done), .dbg_addr(dbg_addr)
  );

  // Full-size instance with default parameters
  logic        b_rst, b_rx_valid, b_tx_start, b_proc_start, b_mem_we, b_xfer_done;
  logic [7:0]  b_rx_data, b_tx_data, b_mem_wdata;
  logic [15:0] b_mem_addr, b_dbg_addr;
  logic [2:0]  b_state_led;

  image_transfer_scheduler big_dut (
    .clk(clk), .rst(b_rst), .rx_valid(b_rx_valid), .rx_data(b_rx_data),
    .tx_busy(1'b0), .tx_start(b_tx_start), .tx_data(b_tx_data),
    .proc_start(b_proc_start), .proc_done(1'b0),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_rdata(8'h00),
    .state_led(b_state_led), .xfer_done(b_xfer_done), .dbg_addr(b_dbg_addr)
  );

  // ---------------- check / scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [23:0] exp_wr_q[$];   // {addr, data}
  logic [7:0]  exp_tx_q[$];
  int n_tx_start   = 0;
  int n_proc_start = 0;

  // ---------------- memory and UART models ----------------
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int   busy_cnt   = 0;
  int   busy_len   = 10;
  logic force_busy = 1'b0;
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || force_busy;

  // Monitor on the inactive edge
  always @(negedge clk) begin
    if (mem_we) begin
      check("write_expected", exp_wr_q.size() != 0, 1);
      if (exp_wr_q.size() != 0) begin
        logic [23:0] e;
        e = exp_wr_q.pop_front();
        check("write_addr", mem_addr, e[23:8]);
        check("write_dbg_addr", dbg_addr, e[23:8]);
        check("write_data", mem_wdata, e[7:0]);
      end
    end
    if (tx_start) begin
      n_tx_start++;
      check("tx_busy_at_start", tx_busy, 0);
      check("tx_expected", exp_tx_q.size() != 0, 1);
      if (exp_tx_q.size() != 0) check("tx_data", tx_data, exp_tx_q.pop_front());
    end
    if (proc_start) n_proc_start++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0; proc_done = 1'b0; force_busy = 1'b0;
    tick();
    check("rst_tx_start", tx_start, 0);
    check("rst_proc_start", proc_start, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_state", state_led, ST_IDLE);
    check("rst_tx_data", tx_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_xfer_done", xfer_done, 0);
    rst = 1'b0;
    exp_tx_q.delete();
    tick();
    check("idle_to_load", state_led, ST_LOAD);
    check("load_addr0", mem_addr, 0);
  endtask

  task automatic wait_state(input state_t st, input int limit, input string tag);
    for (int i = 0; i < limit && state_led != st; i++) tick();
    check(tag, state_led, st);
  endtask

  task automatic load_image(input logic [31:0] img);
    check("in_load", state_led, ST_LOAD);
    for (int i = 0; i < IMG; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      exp_wr_q.push_back({16'(i), img[8*i +: 8]});
      rx_valid = 1'b1;
      rx_data  = img[8*i +: 8];
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    check("proc_start_after_last", proc_start, 1);
    check("enter_proc", state_led, ST_PROC);
  endtask

  task automatic process(input int delay, input bit stale, input bit stray_rx);
    proc_done = stale;
    rx_valid  = stray_rx;
    rx_data   = 8'hEE;
    tick();
    proc_done = 1'b0;
    rx_valid  = 1'b0;
    check("proc_start_single", proc_start, 0);
    repeat (delay - 1) tick();
    check("still_proc", state_led, ST_PROC);
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    check("enter_rd", state_led, ST_RD);
    check("rd_addr_base", mem_addr, BASE);
  endtask

  task automatic dump(input bit stray_wait, input bit hold_off);
    int start_tx;
    int force_cnt;
    int cyc;
    bit forced;
    bit strayed;
    start_tx = n_tx_start; force_cnt = 0; cyc = 0; forced = 0; strayed = 0;
    for (int k = 0; k < OUTN; k++) exp_tx_q.push_back(mem[16'(BASE + k)]);
    while (!xfer_done && cyc < 500) begin
      if (hold_off && !forced && state_led == ST_SEND) begin
        force_busy = 1'b1; forced = 1; force_cnt = 20;
      end else if (force_cnt > 0) begin
        force_cnt--;
        if (force_cnt == 0) begin
          check("holdoff_no_tx", n_tx_start - start_tx, 0);
          force_busy = 1'b0;
        end
      end
      if (stray_wait && !strayed && state_led == ST_WAIT) begin
        rx_valid = 1'b1; strayed = 1;
      end else begin
        rx_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    rx_valid = 1'b0; force_busy = 1'b0;
    check("dump_finished", xfer_done, 1);
    check("tx_count", n_tx_start - start_tx, OUTN);
    check("tx_queue_empty", exp_tx_q.size(), 0);
    check("done_state", state_led, ST_DONE);
  endtask

  task automatic run_transfer(input logic [31:0] img, input int delay, input bit stale,
                              input bit stray_rx, input bit stray_wait, input bit hold_off);
    int ps0;
    ps0 = n_proc_start;
    load_image(img);
    check("writes_consumed", exp_wr_q.size(), 0);
    process(delay, stale, stray_rx);
    dump(stray_wait, hold_off);
    check("proc_start_once", n_proc_start - ps0, 1);
    rx_valid = 1'b1; proc_done = 1'b1;
    repeat (3) tick();
    rx_valid = 1'b0; proc_done = 1'b0;
    check("done_terminal", state_led, ST_DONE);
    check("done_xfer", xfer_done, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_bad;
    logic [15:0] b_last;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; proc_done = 1'b0;
    b_rst = 1'b1; b_rx_valid = 1'b0; b_rx_data = 8'h00;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

    // Directed load and dump
    do_reset();
    mem[16'h10] = 8'h5A; mem[16'h11] = 8'h6B; busy_len = 10;
    run_transfer(32'hD4C3B2A1, 5, 0, 0, 0, 0);

    // Stray rx in PROC and WAIT, stale proc_done on PROC entry
    do_reset();
    mem[16'h10] = 8'($urandom); mem[16'h11] = 8'($urandom); busy_len = 4;
    run_transfer($urandom, 1, 1, 1, 1, 0);

    // Busy hold-off at the first SEND
    do_reset();
    mem[16'h10] = 8'($urandom); mem[16'h11] = 8'($urandom); busy_len = 3;
    run_transfer($urandom, 3, 0, 0, 0, 1);

    // Reset during WAIT of byte 0, then a fresh transfer
    do_reset();
    mem[16'h10] = 8'($urandom); mem[16'h11] = 8'($urandom); busy_len = 8;
    load_image($urandom);
    process(2, 0, 0);
    exp_tx_q.push_back(mem[16'h10]); exp_tx_q.push_back(mem[16'h11]);
    wait_state(ST_WAIT, 50, "reach_wait");
    do_reset();
    run_transfer($urandom, 2, 0, 0, 0, 0);

    // Random transfers
    for (int r = 0; r < 3; r++) begin
      do_reset();
      mem[16'h10] = 8'($urandom); mem[16'h11] = 8'($urandom);
      busy_len = $urandom_range(1, 12);
      run_transfer($urandom, $urandom_range(1, 8), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom));
    end

    // Full-size load on the default-parameter instance
    b_bad = 0; b_last = 16'h0000;
    tick();
    b_rst = 1'b0;
    tick();
    check("big_in_load", b_state_led, ST_LOAD);
    for (int i = 0; i < 65536; i++) begin
      b_rx_valid = 1'b1;
      b_rx_data  = 8'(i * 7 + 3);
      #1;
      if (b_mem_we !== 1'b1 || b_mem_addr !== 16'(i) || b_dbg_addr !== 16'(i) ||
          b_mem_wdata !== 8'(i * 7 + 3)) b_bad++;
      if (b_mem_we === 1'b1) b_last = b_mem_addr;
      tick();
    end
    b_rx_valid = 1'b1;
    #1;
    check("big_no_write_in_proc", b_mem_we, 0);
    check("big_bad_writes", b_bad, 0);
    check("big_last_addr", b_last, 16'hFFFF);
    check("big_enter_proc", b_state_led, ST_PROC);
    check("big_proc_start", b_proc_start, 1);
    check("big_no_tx", b_tx_start, 0);
    check("big_not_done", b_xfer_done, 0);
    tick();
    b_rx_valid = 1'b0;
    check("big_stays_proc", b_state_led, ST_PROC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
